// File: rtl/id_ex_pipe_reg.sv
// Decode->Execute pipeline register for the pipelined MIPS core.
// Holds decoder controls, register-file read data, specifiers and immediate
// for one cycle, with stall (hold), flush (bubble) and a saturating bubble
// counter for performance debug.
module id_ex_pipe_reg #(
    parameter int WIDTH   = 32,
    parameter int REGBITS = 5,
    parameter int CNTW    = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               stall_e,
    input  logic               flush_e,
    input  logic               valid_d,
    input  logic               regwrite_d,
    input  logic               memtoreg_d,
    input  logic               memwrite_d,
    input  logic               alusrc_d,
    input  logic               regdst_d,
    input  logic [2:0]         alucontrol_d,
    input  logic [WIDTH-1:0]   rd1_d,
    input  logic [WIDTH-1:0]   rd2_d,
    input  logic [REGBITS-1:0] rs_d,
    input  logic [REGBITS-1:0] rt_d,
    input  logic [REGBITS-1:0] rd_d,
    input  logic [WIDTH-1:0]   signimm_d,
    input  logic               cnt_clr,
    output logic               valid_e,
    output logic               regwrite_e,
    output logic               memtoreg_e,
    output logic               memwrite_e,
    output logic               alusrc_e,
    output logic               regdst_e,
    output logic [2:0]         alucontrol_e,
    output logic [WIDTH-1:0]   rd1_e,
    output logic [WIDTH-1:0]   rd2_e,
    output logic [REGBITS-1:0] rs_e,
    output logic [REGBITS-1:0] rt_e,
    output logic [REGBITS-1:0] rd_e,
    output logic [WIDTH-1:0]   signimm_e,
    output logic [CNTW-1:0]    bubble_cnt
);

    // All-zero value of this struct is a NOP bubble with rs/rt = 0,
    // so the hazard unit can never forward into it.
    typedef struct packed {
        logic               valid;
        logic               regwrite;
        logic               memtoreg;
        logic               memwrite;
        logic               alusrc;
        logic               regdst;
        logic [2:0]         alucontrol;
        logic [WIDTH-1:0]   rd1;
        logic [WIDTH-1:0]   rd2;
        logic [REGBITS-1:0] rs;
        logic [REGBITS-1:0] rt;
        logic [REGBITS-1:0] rd;
        logic [WIDTH-1:0]   signimm;
    } idex_t;

    idex_t           pipe_q, pipe_d, load_s;
    logic [CNTW-1:0] cnt_q, cnt_d;

    // Gather the decode-stage fields into one record for loading.
    always_comb begin
        load_s            = '0;
        load_s.valid      = valid_d;
        load_s.regwrite   = regwrite_d;
        load_s.memtoreg   = memtoreg_d;
        load_s.memwrite   = memwrite_d;
        load_s.alusrc     = alusrc_d;
        load_s.regdst     = regdst_d;
        load_s.alucontrol = alucontrol_d;
        load_s.rd1        = rd1_d;
        load_s.rd2        = rd2_d;
        load_s.rs         = rs_d;
        load_s.rt         = rt_d;
        load_s.rd         = rd_d;
        load_s.signimm    = signimm_d;
    end

    // Next pipeline contents: flush beats stall, stall beats load.
    always_comb begin
        pipe_d = pipe_q;
        if (flush_e)       pipe_d = '0;
        else if (!stall_e) pipe_d = load_s;
    end

    // Bubble counter: clear wins, otherwise count flushes and saturate at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr)                     cnt_d = '0;
        else if (flush_e && cnt_q != '1) cnt_d = cnt_q + CNTW'(1);
    end

    // State registers with asynchronous active-low reset to all zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_q <= '0;
            cnt_q  <= '0;
        end else begin
            pipe_q <= pipe_d;
            cnt_q  <= cnt_d;
        end
    end

    assign valid_e      = pipe_q.valid;
    assign regwrite_e   = pipe_q.regwrite;
    assign memtoreg_e   = pipe_q.memtoreg;
    assign memwrite_e   = pipe_q.memwrite;
    assign alusrc_e     = pipe_q.alusrc;
    assign regdst_e     = pipe_q.regdst;
    assign alucontrol_e = pipe_q.alucontrol;
    assign rd1_e        = pipe_q.rd1;
    assign rd2_e        = pipe_q.rd2;
    assign rs_e         = pipe_q.rs;
    assign rt_e         = pipe_q.rt;
    assign rd_e         = pipe_q.rd;
    assign signimm_e    = pipe_q.signimm;
    assign bubble_cnt   = cnt_q;

endmodule
